cache_fill_fsm: RTL

Miss handler for one 2-way, 64-set cache with 16-byte blocks (eight 16-bit words). Sits directly upstream of the LRU array. It drives the one-hot set enable, reads block0_isLRU/block1_isLRU to pick the victim way, and fetches the block from pipelined memory. It writes the block into the data and tag arrays, then writes the LRU array so that the filled way becomes MRU.

---
 rtl/cache_fill_fsm.sv | 97 +++++++++
 1 files changed

// File: rtl/cache_fill_fsm.sv
// Miss handler for a 2-way, 64-set cache: picks the victim way from the LRU array,
// streams an 8-word block in from pipelined memory, then writes the tag and marks the filled way MRU.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              block0_isLRU,
  input  logic              block1_isLRU,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic [63:0]       set_enable,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              data_write_en,
  output logic              data_way,
  output logic [2:0]        data_word,
  output logic              tag_write_en,
  output logic              lru_write_en,
  output logic              lru_block,
  output logic              fsm_busy,
  output logic              fill_done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [2:0] LAST    = 3'(WORDS - 1);

  logic [1:0]        r_state;
  logic [2:0]        r_issue_cnt;
  logic [3:0]        r_recv_cnt;
  logic              r_victim;
  logic [ADDR_W-5:0] r_blk;

  logic       w_fill;
  logic       w_wr;
  logic       w_all_rcvd;
  logic [5:0] w_idx;
  logic       w_unused;

  assign w_fill     = (r_state == S_ISSUE) || (r_state == S_WAIT);
  // recv_cnt[3] marks a complete block; anything beyond the 8th word is dropped
  assign w_wr       = w_fill && memory_data_valid && !r_recv_cnt[3];
  assign w_all_rcvd = r_recv_cnt[3] || (w_wr && (r_recv_cnt[2:0] == LAST));

  // Index comes from the latched block once accepted so a moving miss_address cannot retarget the fill
  assign w_idx = (r_state == S_IDLE) ? miss_address[9:4] : r_blk[5:0];
  assign set_enable = (rst && ((r_state != S_IDLE) || miss_detected)) ? (64'd1 << w_idx) : 64'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_victim    <= 1'b0;
      r_blk       <= '0;
    end else begin
      if (w_wr) r_recv_cnt <= r_recv_cnt + 4'd1;
      case (r_state)
        S_IDLE: begin
          if (miss_detected) begin
            r_state     <= S_ISSUE;
            r_blk       <= miss_address[ADDR_W-1:4];
            r_victim    <= block1_isLRU & ~block0_isLRU;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
          end
        end
        S_ISSUE: begin
          if (r_issue_cnt == LAST) r_state <= w_all_rcvd ? S_DONE : S_WAIT;
          else                     r_issue_cnt <= r_issue_cnt + 3'd1;
        end
        S_WAIT:  if (w_all_rcvd) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_read_en    = (r_state == S_ISSUE);
  assign memory_address = mem_read_en ? {r_blk, r_issue_cnt, 1'b0} : '0;
  assign data_write_en  = w_wr;
  assign data_way       = r_victim;
  assign data_word      = w_wr ? r_recv_cnt[2:0] : 3'd0;
  assign tag_write_en   = (r_state == S_DONE);
  assign lru_write_en   = (r_state == S_DONE);
  assign fill_done      = (r_state == S_DONE);
  // LRU array takes the way that becomes LRU, i.e. the one not just filled
  assign lru_block      = (r_state == S_DONE) & ~r_victim;
  assign fsm_busy       = (r_state != S_IDLE);

  // Returned data goes straight to the data array; the offset bits never matter here
  assign w_unused = ^{memory_data, miss_address[3:0]};
endmodule
